// File: rtl/speech_uart_pkg.sv
// Shared types for the UART audio sample path: parser states, sample type, default sync marker.
package speech_uart_pkg;

  typedef enum logic [2:0] {StHunt, StLen, StLo, StHi, StCsum} state_e;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

  typedef logic [15:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead sample FIFO; head entry is visible on data_o whenever not empty.
module sample_fifo
  import speech_uart_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  sample_t                  data_i,
  input  logic                     pop_i,
  output sample_t                  data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  sample_t         mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LvlW'(Depth));
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot the push lands in, so a full FIFO accepts push+pop together.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop)      level_d = level_q + LvlW'(1);
    else if (do_pop && !do_push) level_d = level_q - LvlW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_sample_assembler.sv
// Parses SYNC/LEN/payload/CSUM packets from the UART byte stream into 16-bit PCM samples.
// Define SAMPLE_TIMEOUT_EN to abort a packet after TIMEOUT_CYC idle cycles.
module uart_sample_assembler
  import speech_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [7:0]  SYNC_BYTE   = SyncByteDefault
`ifdef SAMPLE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 2048
`endif
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [7:0]                    RX_DATA,
  input  logic                          RX_VLD,
  input  logic                          RX_FERR,
  output logic [15:0]                   SAMPLE_OUT,
  output logic                          SAMPLE_VLD,
  input  logic                          SAMPLE_RDY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          PKT_DONE,
  output logic                          PKT_ERR,
  output logic                          OVERFLOW
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] xor_q, xor_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       ovf_q, ovf_d;
  logic       push, fifo_full, fifo_empty, drop;
  sample_t    push_data, head;

  assign push_data = {RX_DATA, lo_q};
  assign drop      = push && fifo_full && !SAMPLE_RDY;

`ifdef SAMPLE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC) + 1;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_hit;

  assign tmo_hit = (state_q != StHunt) && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = tmo_q + TmoW'(1);
    if (state_q == StHunt || RX_VLD || RX_FERR) tmo_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    xor_d   = xor_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ovf_d   = ovf_q | drop;
    push    = 1'b0;
    // Frame error beats a simultaneous byte strobe; the byte is dropped.
    if (RX_FERR) begin
      if (state_q != StHunt) begin
        state_d = StHunt;
        err_d   = 1'b1;
      end
    end else if (RX_VLD) begin
      unique case (state_q)
        StHunt: if (RX_DATA == SYNC_BYTE) state_d = StLen;
        StLen: begin
          if (RX_DATA == 8'd0) begin
            state_d = StHunt;
          end else begin
            cnt_d   = RX_DATA;
            xor_d   = 8'd0;
            state_d = StLo;
          end
        end
        StLo: begin
          lo_d    = RX_DATA;
          xor_d   = xor_q ^ RX_DATA;
          state_d = StHi;
        end
        StHi: begin
          push    = 1'b1;
          xor_d   = xor_q ^ RX_DATA;
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? StCsum : StLo;
        end
        StCsum: begin
          done_d  = (RX_DATA == xor_q);
          err_d   = (RX_DATA != xor_q);
          state_d = StHunt;
        end
        default: state_d = StHunt;
      endcase
    end
`ifdef SAMPLE_TIMEOUT_EN
    else if (tmo_hit) begin
      state_d = StHunt;
      err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StHunt;
      cnt_q   <= 8'd0;
      lo_q    <= 8'd0;
      xor_q   <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      xor_q   <= xor_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  sample_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (SAMPLE_RDY),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (FIFO_LEVEL)
  );

  assign SAMPLE_OUT = head;
  assign SAMPLE_VLD = !fifo_empty;
  assign PKT_DONE   = done_q;
  assign PKT_ERR    = err_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_uart_sample_assembler.sv
// Randomized packet stream against a queue-based reference of the sample FIFO and packet pulses.
module tb_uart_sample_assembler;

  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_vld, rx_ferr, sample_rdy;
  logic [15:0] sample_out;
  logic        sample_vld, pkt_done, pkt_err, overflow;
  logic [4:0]  fifo_level;

  always #5 clk = ~clk;

  uart_sample_assembler #(
    .FIFO_DEPTH (Depth)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .RX_DATA    (rx_data),
    .RX_VLD     (rx_vld),
    .RX_FERR    (rx_ferr),
    .SAMPLE_OUT (sample_out),
    .SAMPLE_VLD (sample_vld),
    .SAMPLE_RDY (sample_rdy),
    .FIFO_LEVEL (fifo_level),
    .PKT_DONE   (pkt_done),
    .PKT_ERR    (pkt_err),
    .OVERFLOW   (overflow)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mq[$];
  logic [15:0] pay[$];
  bit          m_ovf, e_done, e_err;
  int          rdy_mode;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("sample_vld", {31'd0, sample_vld}, {31'd0, mq.size() > 0});
    check_eq("fifo_level", {27'd0, fifo_level}, mq.size());
    if (mq.size() > 0) check_eq("sample_out", {16'd0, sample_out}, {16'd0, mq[0]});
    check_eq("pkt_done", {31'd0, pkt_done}, {31'd0, e_done});
    check_eq("pkt_err", {31'd0, pkt_err}, {31'd0, e_err});
    check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  // One clock: check current outputs, drive inputs, advance the reference for the coming edge.
  task automatic step(input bit vld, input logic [7:0] data, input bit ferr, input bit is_push,
                      input logic [15:0] smp, input bit pd, input bit pe);
    bit rdy;
    check_outputs();
    case (rdy_mode)
      0:       rdy = ($urandom_range(0, 3) != 0);
      1:       rdy = 1'b1;
      default: rdy = 1'b0;
    endcase
    rx_vld     = vld;
    rx_data    = data;
    rx_ferr    = ferr;
    sample_rdy = rdy;
    if (rdy && mq.size() > 0) mq.delete(0);
    if (is_push) begin
      if (mq.size() == Depth) m_ovf = 1'b1;
      else mq.push_back(smp);
    end
    e_done = pd;
    e_err  = pe;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] b, input bit is_push, input logic [15:0] smp,
                      input bit pd, input bit pe);
    idle($urandom_range(0, 2));
    step(1'b1, b, 1'b0, is_push, smp, pd, pe);
  endtask

  task automatic send_ferr();
    idle($urandom_range(0, 2));
    step($urandom_range(0, 1) == 1, 8'($urandom), 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  // mode 0: good checksum, 1: corrupted checksum, 2: frame error replacing byte ferr_at.
  task automatic send_packet(input int mode, input int ferr_at);
    int          n;
    logic [7:0]  x;
    logic [7:0]  c;
    logic [15:0] s;
    n = pay.size();
    x = 8'h00;
    send(8'hA5, 1'b0, 16'h0, 1'b0, 1'b0);
    if (mode == 2 && ferr_at == 1) begin send_ferr(); return; end
    send(8'(n), 1'b0, 16'h0, 1'b0, 1'b0);
    if (n == 0) return;
    for (int i = 0; i < n; i++) begin
      s = pay[i];
      if (mode == 2 && ferr_at == 2 + 2 * i) begin send_ferr(); return; end
      send(s[7:0], 1'b0, 16'h0, 1'b0, 1'b0);
      x = x ^ s[7:0];
      if (mode == 2 && ferr_at == 3 + 2 * i) begin send_ferr(); return; end
      send(s[15:8], 1'b1, s, 1'b0, 1'b0);
      x = x ^ s[15:8];
    end
    if (mode == 2) begin send_ferr(); return; end
    c = (mode == 1) ? (x ^ 8'($urandom_range(1, 255))) : x;
    send(c, 1'b0, 16'h0, mode != 1, mode == 1);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    rx_vld  = 1'b0;
    rx_ferr = 1'b0;
    @(posedge clk);
    mq.delete();
    m_ovf  = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_sample_out", {16'd0, sample_out}, 32'h0);
    check_outputs();
  endtask

  task automatic fill_random(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(16'($urandom));
  endtask

  initial begin
    int n, mode, fa;
    logic [7:0] g;
    rst        = 1'b1;
    rx_data    = 8'h00;
    rx_vld     = 1'b0;
    rx_ferr    = 1'b0;
    sample_rdy = 1'b0;
    rdy_mode   = 1;
    repeat (2) @(negedge clk);
    do_reset();

    // Directed: good packet, bad checksum, frame error then garbage, next good packet.
    pay = '{16'h1234, 16'hABCD};
    send_packet(0, 0);
    idle(4);
    send_packet(1, 0);
    idle(4);
    send_packet(0, 0);
    send_packet(2, 3);
    send(8'h00, 1'b0, 16'h0, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 16'h0, 1'b0, 1'b0);
    send_packet(0, 0);
    idle(4);

    // Directed overflow: 17 samples into a 16-deep FIFO with the consumer stalled.
    rdy_mode = 2;
    fill_random(17);
    send_packet(0, 0);
    idle(2);
    check_eq("ovf_level", {27'd0, fifo_level}, Depth);
    rdy_mode = 1;
    idle(Depth + 2);

    // Directed reset after LEN byte.
    send(8'hA5, 1'b0, 16'h0, 1'b0, 1'b0);
    send(8'h05, 1'b0, 16'h0, 1'b0, 1'b0);
    do_reset();
    pay = '{16'h1234, 16'hABCD};
    send_packet(0, 0);
    idle(4);

    // Randomized stream with hunt-state garbage and frame errors.
    for (int p = 0; p < 60; p++) begin
      rdy_mode = ($urandom_range(0, 4) == 0) ? 2 : 0;
      n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(1, 8));
      fill_random(n);
      mode = $urandom_range(0, 3);
      if (mode == 3) mode = 0;
      fa = $urandom_range(1, (n == 0) ? 1 : 2 * n + 2);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send(g, 1'b0, 16'h0, 1'b0, 1'b0);
      end
      if ($urandom_range(0, 5) == 0) step(1'b0, 8'h00, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      send_packet(mode, fa);
    end

    rdy_mode = 1;
    idle(Depth + 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_sample_assembler.md
Name: uart_sample_assembler

Overview:
- Sits directly downstream of the UART receiver. Consumes its DATA_OUT / DATA_VLD / FRAME_ERROR byte stream.
- Parses framed audio packets from that stream and assembles little-endian 16-bit PCM samples.
- Buffers the samples in a small FIFO and hands them to the speech feature-extraction front end over a valid/ready interface.

Parameters:
- FIFO_DEPTH, 16, sample FIFO entries; power of 2, at least 2.
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT_CYC, 2048, inter-byte timeout in CLK cycles. Used only with SAMPLE_TIMEOUT_EN. One byte at 115200 baud on a 3.684 MHz clock is about 320 cycles.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- RX_DATA  in  8  received byte, driven from UART DATA_OUT
- RX_VLD  in  1  one-cycle strobe, driven from UART DATA_VLD
- RX_FERR  in  1  one-cycle strobe, driven from UART FRAME_ERROR
- SAMPLE_OUT  out  16  head-of-FIFO sample, show-ahead
- SAMPLE_VLD  out  1  FIFO not empty
- SAMPLE_RDY  in  1  consumer pop; a pop occurs when SAMPLE_VLD && SAMPLE_RDY
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy
- PKT_DONE  out  1  one-cycle pulse: packet ended with a good checksum
- PKT_ERR  out  1  one-cycle pulse: bad checksum, frame error or timeout
- OVERFLOW  out  1  sticky; a sample was dropped because the FIFO was full

Behaviour:
- Reset:
  - Taken on the next CLK edge with RST=1; overrides all other activity.
  - FSM goes to HUNT and the FIFO is emptied.
  - SAMPLE_VLD, PKT_DONE, PKT_ERR and OVERFLOW go to 0; FIFO_LEVEL goes to 0; SAMPLE_OUT goes to 16'h0000.
  - A packet in progress is discarded.
- Packet format: SYNC_BYTE, LEN (N samples, 1..255), then 2N payload bytes (lo, hi per sample), then CSUM = XOR of all 2N payload bytes.
- FSM, advanced only on RX_VLD:
  - HUNT: byte == SYNC_BYTE -> LEN; any other byte is ignored.
  - LEN: N == 0 -> HUNT with no pulse; otherwise latch N, clear the running XOR -> LO.
  - LO: latch the low byte, XOR it in -> HI.
  - HI: form {hi, lo}, XOR in hi, push to the FIFO, decrement the count; count reaches 0 -> CSUM, else -> LO.
  - CSUM: byte == running XOR -> PKT_DONE pulse; else -> PKT_ERR pulse. Either way -> HUNT.
- A payload byte equal to SYNC_BYTE has no special meaning outside HUNT.
- RX_FERR:
  - In any state other than HUNT: -> HUNT and PKT_ERR pulse; the partial low byte is discarded.
  - In HUNT: ignored.
  - RX_FERR and RX_VLD in the same cycle: RX_FERR wins and the byte is dropped.
- Samples already pushed from a failed packet stay in the FIFO. The consumer uses PKT_ERR to discard them.
- Latency: RX_VLD on a hi byte at edge t -> sample written at edge t; it appears on SAMPLE_OUT with SAMPLE_VLD=1 at t+1 if the FIFO was empty. There is no combinational bypass.
- PKT_DONE / PKT_ERR are asserted in the cycle after the accepting edge, for exactly one cycle.
- FIFO rules:
  - Push when full with no pop in the same cycle: sample dropped, OVERFLOW set, FSM continues normally.
  - Push when full with a pop in the same cycle: both accepted, level unchanged.
  - Pop when empty: ignored.
  - Push and pop together when not full: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; FIFO_LEVEL reaches FIFO_DEPTH exactly when full.

Optional Feature:
- Macro: SAMPLE_TIMEOUT_EN.
- Defined:
  - A counter runs whenever the FSM is not in HUNT; it clears on RX_VLD.
  - Reaching TIMEOUT_CYC-1 -> HUNT and PKT_ERR pulse.
  - If the timeout and RX_VLD occur in the same cycle, the byte wins.
- Undefined: no counter; the FSM waits indefinitely for the next byte.

Decomposition:
- Package speech_uart_pkg holds:
  - the FSM state enum (HUNT, LEN, LO, HI, CSUM);
  - the default SYNC_BYTE constant;
  - typedef sample_t (16-bit).
- One sub-module, sample_fifo: a synchronous show-ahead FIFO with push, pop, full, empty and level. The parser FSM stays in the top-level module.

Test Plan:
- Good packet: bytes A5, 02, 34, 12, CD, AB, CSUM=34^12^CD^AB=40, SAMPLE_RDY=1 -> SAMPLE_OUT shows 1234 then ABCD; PKT_DONE pulses once; FIFO_LEVEL returns to 0.
- Bad checksum: same packet with CSUM=41 -> both samples delivered, then PKT_ERR pulses once; FSM back in HUNT; the next good packet is accepted.
- Frame error: RX_FERR after byte 34 of the packet above -> PKT_ERR pulses; FIFO_LEVEL=0; garbage bytes 00, FF before the next A5 are ignored.
- Overflow: FIFO_DEPTH=16, SAMPLE_RDY=0, packet with N=17 -> FIFO_LEVEL=16, OVERFLOW=1, the 17th sample is lost. Then SAMPLE_RDY=1 -> 16 samples drained in order.
- Reset mid-packet: RST=1 for one cycle after the LEN byte -> all outputs at their reset values; the following packet parses correctly.
- SAMPLE_TIMEOUT_EN, TIMEOUT_CYC=2048: A5, 01, 34, then silence -> PKT_ERR pulses 2048 cycles after the 34 strobe; no sample is pushed.
